// File: rtl/seq_shift_pkg.sv
// Shared types for the sequential shifter: FSM states, op codes and op decoding.
// SEQ_SHIFT_ARITH_EN enables the arithmetic right shift (op = 10); otherwise it decodes as SRL.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SLL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  // Collapse the raw op field onto the operations this build actually implements.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      OP_SLL: return OP_SLL;
`ifdef SEQ_SHIFT_ARITH_EN
      OP_SRA: return OP_SRA;
`endif
      default: return OP_SRL;
    endcase
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shifter: produces the working value after a single shift step.
// Sign refill for SRA exists only when SEQ_SHIFT_ARITH_EN is defined.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] value,
  input  op_e          op,
  input  logic         sign,
  output logic [N-1:0] next
);

`ifndef SEQ_SHIFT_ARITH_EN
  logic unused_sign;
  assign unused_sign = sign;
`endif

  // NOTE: next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next = {1'b0, value[N-1:1]};
    case (op)
      OP_SLL: next = {value[N-2:0], 1'b0};
`ifdef SEQ_SHIFT_ARITH_EN
      OP_SRA: next = {sign, value[N-1:1]};
`endif
      default: next = {1'b0, value[N-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Sequential barrel-free shifter: one bit per clock through IDLE -> SHIFT -> DONE with
// valid/ready handshakes on both sides. SEQ_SHIFT_ARITH_EN enables SRA (op = 10).
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam int CW = $clog2(N);

  state_e        state;
  op_e           op_q;
  op_e           op_n;
  logic [N-1:0]  work;
  logic [N-1:0]  step_next;
  logic [N-1:0]  sat;
  logic [CW-1:0] cnt;
  logic          b_big;

  assign op_n  = decode_op(op);
  assign b_big = |b[N-1:CW];
  assign out   = work;

  // Shifting by N or more leaves nothing of a but (for SRA) its sign.
`ifdef SEQ_SHIFT_ARITH_EN
  assign sat = (op_n == OP_SRA) ? {N{a[N-1]}} : '0;
`else
  assign sat = '0;
`endif

  shift_step #(.N(N)) u_step (
    .value (work),
    .op    (op_q),
    .sign  (work[N-1]),
    .next  (step_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_SRL;
      work      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= SHIFT;
            op_q     <= op_n;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (b_big) begin
              work <= sat;
              cnt  <= '0;
            end else begin
              work <= a;
              cnt  <= b[CW-1:0];
            end
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= step_next;
            cnt  <= cnt - 1'b1;
          end else begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // in_ready is registered, so a new operand can only be taken the cycle after handoff.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand and result width; N is a power of two and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; every flop samples on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  the operand set on a, b and op is valid.
REQ-005 SHALL have port in_ready  output  1  the unit can accept a new operand set.
REQ-006 SHALL have port a  input  N  value to be shifted.
REQ-007 SHALL have port b  input  N  unsigned shift amount.
REQ-008 SHALL have port op  input  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 reserved.
REQ-009 SHALL have port out_valid  output  1  the value on out is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-011 SHALL have port out  output  N  shifted result.
REQ-012 SHALL have port busy  output  1  high in the SHIFT and DONE states.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready high only in IDLE; an operand set is accepted on a rising edge where in_valid and in_ready are both high.
REQ-015 SHALL, on accept, register a and op, and move to SHIFT.
REQ-016 SHALL, on accept with b < N, load a down-counter cnt of width clog2(N) with b[clog2(N)-1:0].
REQ-017 SHALL, on accept with b >= N (any bit of b[N-1:clog2(N)] set), load the saturated result directly and set cnt to 0. The saturated result is 0 for SRL and SLL, and N copies of a[N-1] for SRA.
REQ-018 SHALL, in SHIFT with cnt != 0, shift the working register by one bit per cycle and decrement cnt.
REQ-019 SHALL use these one-bit shifts: SRL fills with 0 at the MSB; SLL fills with 0 at the LSB; SRA refills the MSB with the sign bit.
REQ-020 SHALL, in SHIFT with cnt == 0, move to DONE; out_valid is high in DONE only.
REQ-021 SHALL give latency: out_valid rises k+1 clocks after the accept edge, where k is the loaded cnt value.
REQ-022 SHALL drive out from the working register at all times; out is stable throughout DONE.
REQ-023 SHALL, in DONE, hold until out_valid and out_ready are both high on an edge, then return to IDLE.
REQ-024 SHALL NOT combinationally pass a new accept through in the same cycle as the DONE handoff; in_ready rises on the cycle after the handoff.
REQ-025 SHALL ignore in_valid, a, b and op outside IDLE.
REQ-026 SHALL treat op = 11 exactly as SRL.

Reset
REQ-027 SHALL, while rst_n is low, force the state to IDLE, out to 0, cnt to 0, out_valid to 0, busy to 0 and in_ready to 1, independent of clk.
REQ-028 SHALL, if reset is asserted in SHIFT or DONE, discard the operation in flight; no result is produced after reset is released.

Configuration
REQ-029 SHALL support the macro SEQ_SHIFT_ARITH_EN.
REQ-030 SHALL, when SEQ_SHIFT_ARITH_EN is defined, implement SRA (op = 10) as specified above.
REQ-031 SHALL, when SEQ_SHIFT_ARITH_EN is undefined, treat op = 10 as SRL and compile no sign-fill logic.

Structure
REQ-032 SHALL place the state encoding typedef (IDLE, SHIFT, DONE) and the op code constants (OP_SRL, OP_SLL, OP_SRA) in the shared package seq_shift_pkg.
REQ-033 SHALL use one sub-module, shift_step, a combinational one-bit shifter taking the working value, op and sign bit and returning the next value.

Verification
REQ-034 SHALL cover: a=0xB4, b=3, SRL -> out=0x16, out_valid high 4 clocks after accept.
REQ-035 SHALL cover: a=0xB4, b=3, SRA -> out=0xF6 with the macro defined and 0x16 without; a=0x0F, b=4, SLL -> out=0xF0.
REQ-036 SHALL cover: a=0x80, b=0x20, SRA -> out=0xFF (macro defined); a=0xFF, b=0x09, SRL -> out=0x00; both with out_valid high 1 clock after accept.
REQ-037 SHALL cover: b=0 -> out=a, out_valid high 1 clock after accept.
REQ-038 SHALL cover: out_ready held low for 5 cycles in DONE, with in_valid pulsed and a new a and b applied -> out held stable, in_ready stays 0, the new operands are not captured.
REQ-039 SHALL cover: rst_n pulsed low mid-SHIFT while b=7 -> outputs go to their reset values immediately; after release in_ready=1 and no stale out_valid appears.
